// File: rtl/relu_vec_serializer.sv
// -----------------------------------------------------------------------------
// relu_vec_serializer
//
// Reader end of the ReLu output interface. Captures a whole LENGTH-element
// activation vector (plus its unified-buffer base address) in a single
// vec_valid/vec_ready handshake, then streams the elements in index order,
// one per cycle, over an out_valid/out_ready handshake with an auto-
// incrementing write address. Data passes through untouched.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   vec_valid  upstream has a complete vector on vec_in
//   vec_ready  a vector can be captured this cycle (IDLE and not in reset)
//   vec_in     LENGTH x DATA_WIDTH unpacked array, ReLu output vector
//   base_addr  write address of element 0, sampled with the vector
//   out_valid  out_data/out_addr/out_last are valid
//   out_ready  downstream accepts the current element
//   out_data   current element
//   out_addr   write address of the current element (wraps mod 2^ADDR_WIDTH)
//   out_last   current element is index LENGTH-1
//   busy       vector held, streaming in progress
//   done       one-cycle pulse after the last element is accepted
//
// Timing: vector captured at edge N -> element 0 valid after edge N.
// With out_ready held high a vector takes LENGTH+1 cycles including the
// done cycle, and the next vector can be captured in the done cycle.
// -----------------------------------------------------------------------------

// One element holding register. The captured vector is don't-care until the
// next capture, so it carries no reset.
module relu_vec_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (load) q <= din;
    end
endmodule

module relu_vec_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [DATA_WIDTH-1:0] vec_in [0:LENGTH-1],
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    // Keep the index at least one bit wide so LENGTH=1 still elaborates.
    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                            state;
    logic [IDX_W-1:0]                  index;
    logic [IDX_W-1:0]                  idx_nxt;
    logic                              capture;
    logic                              xfer;
    logic [LENGTH-1:0][DATA_WIDTH-1:0] lane_q;

    // vec_ready follows the state directly so it is high in the very first
    // cycle after reset releases and in the done cycle, and low during reset.
    assign vec_ready = (state == IDLE) && !reset;
    assign capture   = vec_valid && vec_ready;
    assign xfer      = out_valid && out_ready;
    assign idx_nxt   = index + IDX_W'(1);

    // Vector buffer: every lane loads on the capture handshake.
    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        relu_vec_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk  (clk),
            .load (capture),
            .din  (vec_in[i]),
            .q    (lane_q[i])
        );
    end

    // Output registers are loaded one element ahead: on capture element 0 is
    // taken straight from vec_in (the lanes load on the same edge), and on
    // each accepted transfer the next element is fetched from the lanes.
    // Holding these registers when out_ready is low gives stall stability.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        state     <= STREAM;
                        index     <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_data  <= vec_in[0];
                        out_addr  <= base_addr;
                        out_last  <= (LENGTH == 1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= IDLE;
                            index     <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            index    <= idx_nxt;
                            out_data <= lane_q[idx_nxt];
                            // Address wraps silently at 2^ADDR_WIDTH.
                            out_addr <= out_addr + ADDR_WIDTH'(1);
                            out_last <= (idx_nxt == IDX_W'(LENGTH - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_relu_vec_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for relu_vec_serializer. Inputs change on the falling edge and
// outputs are sampled on the falling edge. The expected element stream is
// built from the captured vector with plain arithmetic (data as captured,
// address = base + i mod 256, last only at i = LENGTH-1).
// -----------------------------------------------------------------------------
module tb_relu_vec_serializer;
    localparam int DW  = 16;
    localparam int LEN = 32;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          vec_valid;
    logic          vec_ready;
    logic [DW-1:0] vec_in [0:LEN-1];
    logic [AW-1:0] base_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    logic          exp_last [$];
    logic [DW-1:0] got_data [$];
    logic [AW-1:0] got_addr [$];
    logic          got_last [$];

    always #5 clk = ~clk;

    relu_vec_serializer #(.DATA_WIDTH(DW), .LENGTH(LEN), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_in    (vec_in),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // mode 0: random, 1: i+1, 2: all ones
    task automatic fill_vec(input int mode, input logic [AW-1:0] base);
        base_addr = base;
        for (int i = 0; i < LEN; i++) begin
            case (mode)
                1:       vec_in[i] = DW'(i + 1);
                2:       vec_in[i] = '1;
                default: vec_in[i] = DW'($urandom);
            endcase
        end
    endtask

    // Reference stream for whatever is on vec_in/base_addr right now.
    task automatic build_exp();
        exp_data.delete(); exp_addr.delete(); exp_last.delete();
        for (int i = 0; i < LEN; i++) begin
            exp_data.push_back(vec_in[i]);
            exp_addr.push_back(AW'((int'(base_addr) + i) % (1 << AW)));
            exp_last.push_back(i == LEN - 1);
        end
    endtask

    // -1 when the accepted stream equals the reference, -2 on a length
    // difference, else the first differing element index.
    function automatic int stream_diff();
        if (got_data.size() != exp_data.size()) return -2;
        foreach (exp_data[i])
            if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i] ||
                got_last[i] !== exp_last[i]) return i;
        return -1;
    endfunction

    task automatic send();
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    // Drives out_ready (0: always, 1: 1,0,0 pattern, 2: random), collects
    // accepted elements until done. Starts sampling in the current cycle.
    task automatic drain(input int budget, input int rmode, output int cycles,
                         output int stall_bad, output int proto_bad,
                         output logic vr_done, output bit timeout);
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        int            phase;
        got_data.delete(); got_addr.delete(); got_last.delete();
        cycles = 0; stall_bad = 0; proto_bad = 0; vr_done = 1'b0; timeout = 1'b0;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pa = '0; phase = 0;
        forever begin
            cycles++;
            if (pv && !pr && (out_data !== pd || out_addr !== pa || out_last !== pl))
                stall_bad++;
            if (done === 1'b1) begin
                vr_done = vec_ready;
                if (out_valid !== 1'b0 || busy !== 1'b0) proto_bad++;
                break;
            end
            if (out_valid !== 1'b1 || busy !== 1'b1 || vec_ready !== 1'b0) proto_bad++;
            if (cycles > budget) begin
                timeout = 1'b1;
                break;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
            if (out_valid === 1'b1 && out_ready) begin
                got_data.push_back(out_data);
                got_addr.push_back(out_addr);
                got_last.push_back(out_last);
            end
            pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vec_valid = 1'b0; out_ready = 1'b0;
        fill_vec(1, '0);
        repeat (2) @(negedge clk);
        n_total++; if (vec_ready !== 1'b0) $display("FAIL rst vec_ready got %b need 0", vec_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst out_valid got %b need 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst busy got %b need 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst done got %b need 0", done); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL rst out_data got %h need 0", out_data); else n_pass++;
        n_total++; if (out_addr !== '0) $display("FAIL rst out_addr got %h need 0", out_addr); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL rst out_last got %b need 0", out_last); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (vec_ready !== 1'b1) $display("FAIL rst_release vec_ready got %b need 1", vec_ready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, sb, pb, d; logic vr; bit to;
        fill_vec(1, 8'h10); build_exp(); out_ready = 1'b1;
        send();
        drain(LEN + 5, 0, cyc, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to) $display("FAIL basic timeout after %0d cycles", cyc); else n_pass++;
        n_total++; if (d != -1) $display("FAIL basic stream diff at %0d got %0d elems need %0d", d, got_data.size(), LEN); else n_pass++;
        n_total++; if (cyc != LEN + 1) $display("FAIL basic cycles got %0d need %0d", cyc, LEN + 1); else n_pass++;
        n_total++; if (pb != 0) $display("FAIL basic protocol errors got %0d need 0", pb); else n_pass++;
        n_total++; if (vr !== 1'b1) $display("FAIL basic vec_ready_in_done got %b need 1", vr); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL basic done_width got %b need 0", done); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic idle out_valid got %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc, sb, pb, d; logic vr; bit to;
        fill_vec(0, AW'($urandom)); build_exp(); out_ready = 1'b1;
        send();
        drain(4 * LEN, 1, cyc, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to) $display("FAIL bp timeout after %0d cycles", cyc); else n_pass++;
        n_total++; if (d != -1) $display("FAIL bp stream diff at %0d got %0d elems need %0d", d, got_data.size(), LEN); else n_pass++;
        n_total++; if (sb != 0) $display("FAIL bp stall_stability errors got %0d need 0", sb); else n_pass++;
        n_total++; if (pb != 0) $display("FAIL bp protocol errors got %0d need 0", pb); else n_pass++;
        n_total++; if (cyc != 3 * (LEN - 1) + 2) $display("FAIL bp cycles got %0d need %0d", cyc, 3 * (LEN - 1) + 2); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        int cyc, sb, pb, d; logic vr; bit to;
        fill_vec(0, 8'hF0); build_exp(); out_ready = 1'b1;
        send();
        drain(8 * LEN, 2, cyc, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to) $display("FAIL wrap timeout after %0d cycles", cyc); else n_pass++;
        n_total++; if (d != -1) $display("FAIL wrap stream diff at %0d got %0d elems need %0d", d, got_data.size(), LEN); else n_pass++;
        n_total++; if (got_addr.size() != LEN || got_addr[LEN-1] !== 8'h0F)
            $display("FAIL wrap last_addr got %0d elems need addr 0f at last", got_addr.size()); else n_pass++;
        n_total++; if (sb != 0 || pb != 0) $display("FAIL wrap stall/protocol errors got %0d/%0d need 0/0", sb, pb); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_busy_protect();
        int cyc, sb, pb, d; logic vr; bit to;
        fill_vec(0, AW'($urandom)); build_exp(); out_ready = 1'b1;
        vec_valid = 1'b1;
        @(negedge clk);
        fill_vec(2, base_addr);   // vec_valid stays high with a new vector
        drain(LEN + 5, 0, cyc, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to) $display("FAIL busy timeout after %0d cycles", cyc); else n_pass++;
        n_total++; if (d != -1) $display("FAIL busy stream diff at %0d got %0d elems need %0d", d, got_data.size(), LEN); else n_pass++;
        n_total++; if (pb != 0) $display("FAIL busy protocol (vec_ready while streaming) got %0d need 0", pb); else n_pass++;
        build_exp();
        @(negedge clk);
        vec_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1 || out_data !== 16'hFFFF)
            $display("FAIL busy second_capture got valid %b data %h need 1 ffff", out_valid, out_data); else n_pass++;
        drain(LEN + 5, 0, cyc, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to || d != -1) $display("FAIL busy second_stream diff at %0d timeout %0d need -1 0", d, to); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc_a, cyc_b, sb, pb, d; logic vr; bit to;
        fill_vec(0, AW'($urandom)); build_exp(); out_ready = 1'b1;
        vec_valid = 1'b1;
        @(negedge clk);
        fill_vec(0, AW'($urandom));   // vector B waits on the bus
        drain(LEN + 5, 0, cyc_a, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to || d != -1) $display("FAIL b2b stream_a diff at %0d timeout %0d need -1 0", d, to); else n_pass++;
        build_exp();
        @(negedge clk);
        vec_valid = 1'b0;
        drain(LEN + 5, 0, cyc_b, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to || d != -1) $display("FAIL b2b stream_b diff at %0d timeout %0d need -1 0", d, to); else n_pass++;
        n_total++; if (pb != 0) $display("FAIL b2b protocol errors got %0d need 0", pb); else n_pass++;
        n_total++; if (cyc_a + cyc_b != 2 * (LEN + 1))
            $display("FAIL b2b total_cycles got %0d need %0d", cyc_a + cyc_b, 2 * (LEN + 1)); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, sb, pb, d; logic vr; bit to;
        fill_vec(0, AW'($urandom)); build_exp(); out_ready = 1'b1;
        send();
        repeat (5) @(negedge clk);
        n_total++; if (out_data !== exp_data[5] || out_valid !== 1'b1)
            $display("FAIL rmid element5 got %h valid %b need %h 1", out_data, out_valid, exp_data[5]); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid abort got valid %b busy %b need 0 0", out_valid, busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rmid done got %b need 0", done); else n_pass++;
        n_total++; if (vec_ready !== 1'b0 || out_last !== 1'b0) $display("FAIL rmid ready/last got %b %b need 0 0", vec_ready, out_last); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (done !== 1'b0 || vec_ready !== 1'b1) $display("FAIL rmid post got done %b ready %b need 0 1", done, vec_ready); else n_pass++;
        fill_vec(0, AW'($urandom)); build_exp();
        send();
        drain(LEN + 5, 0, cyc, sb, pb, vr, to);
        d = stream_diff();
        n_total++; if (to || d != -1 || cyc != LEN + 1)
            $display("FAIL rmid restream diff %0d timeout %0d cycles %0d need -1 0 %0d", d, to, cyc, LEN + 1); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc, sb, pb, d; logic vr; bit to;
        for (int it = 0; it < 4; it++) begin
            fill_vec(0, AW'($urandom)); build_exp(); out_ready = 1'($urandom_range(0, 1));
            send();
            drain(8 * LEN, 2, cyc, sb, pb, vr, to);
            d = stream_diff();
            n_total++; if (to || d != -1) $display("FAIL rand%0d stream diff %0d timeout %0d need -1 0", it, d, to); else n_pass++;
            n_total++; if (sb != 0 || pb != 0) $display("FAIL rand%0d stall/protocol got %0d/%0d need 0/0", it, sb, pb); else n_pass++;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_addr_wrap();
        test_busy_protect();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
